// File: rtl/traffic_lights_cmd_deframer.sv
// traffic_lights_cmd_deframer
// Assembles fixed-length byte frames from the host link into single-cycle
// commands for the traffic-light controller. A frame is a header byte
// {sync[4:0], type[2:0]} followed by the 16-bit payload, high byte first.
// Bad headers, illegal types, checksum mismatches and inter-byte stalls
// are dropped and counted.
// Optional feature macro: TL_CMD_CHECKSUM_EN (adds a trailing XOR checksum byte).
module traffic_lights_cmd_deframer #(
    parameter int unsigned BYTE_TIMEOUT = 1000,
    parameter int unsigned MAX_CMD_TYPE = 5,
    parameter logic [4:0]  SYNC_PATTERN = 5'b10100
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        frame_err_o,
    output logic [7:0]  err_cnt_o
);

    // The idle counter fires on the cycle it would reach BYTE_TIMEOUT.
    localparam logic [15:0] TIMEOUT_LAST = 16'(BYTE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA_HI = 3'd1,
        DATA_LO = 3'd2,
`ifdef TL_CMD_CHECKSUM_EN
        CHK     = 3'd3,
`endif
        EMIT    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_type;
    logic [7:0]  r_data_hi;
`ifdef TL_CMD_CHECKSUM_EN
    logic [7:0]  r_data_lo;
    logic [7:0]  w_checksum;
`endif
    logic [15:0] r_idle_cnt;
    logic        r_ready;
    logic        r_cmd_valid;
    logic [2:0]  r_cmd_type;
    logic [15:0] r_cmd_data;
    logic        r_frame_err;
    logic [7:0]  r_err_cnt;

    logic        w_hs;
    logic        w_wait;
    logic        w_timeout;
    logic        w_type_legal;
    logic        w_emit;
    logic        w_err;
    logic [15:0] w_frame_data;

    assign w_hs         = byte_valid_i & r_ready;
    assign w_type_legal = ({29'd0, r_type} <= 32'(MAX_CMD_TYPE));
`ifdef TL_CMD_CHECKSUM_EN
    assign w_checksum   = {SYNC_PATTERN, r_type} ^ r_data_hi ^ r_data_lo;
    assign w_wait       = (r_state == DATA_HI) || (r_state == DATA_LO) || (r_state == CHK);
`else
    assign w_wait       = (r_state == DATA_HI) || (r_state == DATA_LO);
`endif
    assign w_timeout    = w_wait && !w_hs && (r_idle_cnt == TIMEOUT_LAST);

    // Next-state decode plus the emit/error decisions that feed the output registers.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_err        = 1'b0;
        w_frame_data = {r_data_hi, byte_data_i};
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (byte_data_i[7:3] == SYNC_PATTERN) begin
                        w_next_state = DATA_HI;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            DATA_HI: begin
                if (w_hs) begin
                    w_next_state = DATA_LO;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_err        = 1'b1;
                end
            end
            DATA_LO: begin
                if (w_hs) begin
`ifdef TL_CMD_CHECKSUM_EN
                    w_next_state = CHK;
`else
                    w_next_state = EMIT;
                    w_emit       = w_type_legal;
                    w_err        = !w_type_legal;
`endif
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_err        = 1'b1;
                end
            end
`ifdef TL_CMD_CHECKSUM_EN
            CHK: begin
                w_frame_data = {r_data_hi, r_data_lo};
                if (w_hs) begin
                    if (byte_data_i == w_checksum) begin
                        w_next_state = EMIT;
                        w_emit       = w_type_legal;
                        w_err        = !w_type_legal;
                    end else begin
                        w_next_state = IDLE;
                        w_err        = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_err        = 1'b1;
                end
            end
`endif
            EMIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and frame field capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_type    <= 3'd0;
            r_data_hi <= 8'd0;
`ifdef TL_CMD_CHECKSUM_EN
            r_data_lo <= 8'd0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_hs && (r_state == IDLE) && (byte_data_i[7:3] == SYNC_PATTERN)) begin
                r_type <= byte_data_i[2:0];
            end
            if (w_hs && (r_state == DATA_HI)) begin
                r_data_hi <= byte_data_i;
            end
`ifdef TL_CMD_CHECKSUM_EN
            if (w_hs && (r_state == DATA_LO)) begin
                r_data_lo <= byte_data_i;
            end
`endif
        end
    end

    // Inter-byte idle counter; restarts on every accepted byte and outside a frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idle_cnt <= 16'd0;
        end else if (w_hs || !w_wait || w_timeout) begin
            r_idle_cnt <= 16'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    // Registered outputs: ready, command strobe/payload, error strobe and saturating count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ready     <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= 3'd0;
            r_cmd_data  <= 16'd0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_ready     <= (w_next_state != EMIT);
            r_cmd_valid <= w_emit;
            if (w_emit) begin
                r_cmd_type <= r_type;
                r_cmd_data <= w_frame_data;
            end
            r_frame_err <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign byte_ready_o = r_ready;
    assign cmd_valid_o  = r_cmd_valid;
    assign cmd_type_o   = r_cmd_type;
    assign cmd_data_o   = r_cmd_data;
    assign frame_err_o  = r_frame_err;
    assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_traffic_lights_cmd_deframer.sv
// tb_traffic_lights_cmd_deframer
// Drives byte frames into the deframer; a frame-level reference model pushes
// expected commands and error counts into queues, and a monitor pops them
// whenever the DUT strobes cmd_valid_o or frame_err_o.
module tb_traffic_lights_cmd_deframer;

    localparam int TIMEOUT  = 10;
    localparam int MAX_TYPE = 5;
    localparam logic [4:0] SYNC = 5'b10100;
`ifdef TL_CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic        clk;
    logic        rstN;
    logic [7:0]  byteData;
    logic        byteValid;
    logic        byteReady;
    logic [2:0]  cmdType;
    logic        cmdValid;
    logic [15:0] cmdData;
    logic        frameErr;
    logic [7:0]  errCnt;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] d;
    } cmd_t;

    cmd_t        cmdQ[$];
    int          errQ[$];
    logic [7:0]  frameBuf[$];
    int          modelErrCnt;
    logic [2:0]  holdType;
    logic [15:0] holdData;
    int          nChecks;
    int          nFails;

    traffic_lights_cmd_deframer #(
        .BYTE_TIMEOUT(TIMEOUT),
        .MAX_CMD_TYPE(MAX_TYPE),
        .SYNC_PATTERN(SYNC)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .byte_data_i  (byteData),
        .byte_valid_i (byteValid),
        .byte_ready_o (byteReady),
        .cmd_type_o   (cmdType),
        .cmd_valid_o  (cmdValid),
        .cmd_data_o   (cmdData),
        .frame_err_o  (frameErr),
        .err_cnt_o    (errCnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelErr();
        if (modelErrCnt < 255) modelErrCnt++;
        errQ.push_back(modelErrCnt);
    endfunction

    // A partial frame left waiting TIMEOUT cycles or more is dropped.
    function automatic void modelStall(input int gap);
        if ((frameBuf.size() > 0) && (gap >= TIMEOUT)) begin
            modelErr();
            frameBuf.delete();
        end
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        logic [7:0] hdr;
        bit         ok;
        if (frameBuf.size() == 0) begin
            if (b[7:3] == SYNC) frameBuf.push_back(b);
            else modelErr();
            return;
        end
        frameBuf.push_back(b);
        if (frameBuf.size() == FRAME_LEN) begin
            hdr = frameBuf[0];
            ok  = 1'b1;
`ifdef TL_CMD_CHECKSUM_EN
            if (frameBuf[3] != (frameBuf[0] ^ frameBuf[1] ^ frameBuf[2])) ok = 1'b0;
`endif
            if (ok && (int'(hdr[2:0]) <= MAX_TYPE)) begin
                cmdQ.push_back('{t: hdr[2:0], d: {frameBuf[1], frameBuf[2]}});
            end else begin
                modelErr();
            end
            frameBuf.delete();
        end
    endfunction

    // Sends one byte after 'gap' idle cycles; called and returns on a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waitCnt;
        modelStall(gap);
        byteValid = 1'b0;
        repeat (gap) @(negedge clk);
        byteData  = b;
        byteValid = 1'b1;
        waitCnt   = 0;
        while (!byteReady && (waitCnt < 20)) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("handshake", {31'd0, byteReady}, 32'd1);
        if (!byteReady) begin
            byteValid = 1'b0;
            return;
        end
        modelByte(b);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        applyStimulus(b0, 0);
        applyStimulus(b1, 0);
        applyStimulus(b2, 0);
`ifdef TL_CMD_CHECKSUM_EN
        applyStimulus(b0 ^ b1 ^ b2, 0);
`endif
    endtask

    task automatic idleCycles(input int n);
        modelStall(n);
        byteValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ready"}, {31'd0, byteReady}, 32'd0);
        checkOutput({tag, " cmd_valid"}, {31'd0, cmdValid}, 32'd0);
        checkOutput({tag, " cmd_type"}, {29'd0, cmdType}, 32'd0);
        checkOutput({tag, " cmd_data"}, {16'd0, cmdData}, 32'd0);
        checkOutput({tag, " frame_err"}, {31'd0, frameErr}, 32'd0);
        checkOutput({tag, " err_cnt"}, {24'd0, errCnt}, 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an output.
    always @(negedge clk) begin
        cmd_t exp;
        if (rstN) begin
            if (cmdValid) begin
                if (cmdQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected cmd: got type %0d data %0h, expected none", cmdType, cmdData);
                end else begin
                    exp = cmdQ.pop_front();
                    checkOutput("cmd_type", {29'd0, cmdType}, {29'd0, exp.t});
                    checkOutput("cmd_data", {16'd0, cmdData}, {16'd0, exp.d});
                    checkOutput("ready in emit", {31'd0, byteReady}, 32'd0);
                    holdType = exp.t;
                    holdData = exp.d;
                end
            end
            if (frameErr) begin
                if (errQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected frame_err: got err_cnt %0d, expected no pulse", errCnt);
                end else begin
                    checkOutput("err_cnt", {24'd0, errCnt}, errQ.pop_front());
                end
                if (!cmdValid) begin
                    checkOutput("hold cmd_type", {29'd0, cmdType}, {29'd0, holdType});
                    checkOutput("hold cmd_data", {16'd0, cmdData}, {16'd0, holdData});
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, randomized frames, then error-counter saturation.
    initial begin
        logic [7:0] b0, b1, b2, ck;
        int g0, g1, g2;
        nChecks     = 0;
        nFails      = 0;
        modelErrCnt = 0;
        holdType    = 3'd0;
        holdData    = 16'd0;
        rstN        = 1'b0;
        byteData    = 8'd0;
        byteValid   = 1'b0;

        #3;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready after release", {31'd0, byteReady}, 32'd1);

        $display("[TB] legal frame A3 0B B8");
        sendFrame(8'hA3, 8'h0B, 8'hB8);

        $display("[TB] illegal type frame A7 12 34");
        sendFrame(8'hA7, 8'h12, 8'h34);

        $display("[TB] bad header 55 then frame A0 00 00");
        applyStimulus(8'h55, 0);
        sendFrame(8'hA0, 8'h00, 8'h00);

        $display("[TB] timeout after header A4");
        applyStimulus(8'hA4, 0);
        applyStimulus(8'h00, TIMEOUT);
        applyStimulus(8'h10, 0);

        $display("[TB] stall just under the timeout");
        applyStimulus(8'hA1, 0);
        applyStimulus(8'h22, TIMEOUT - 1);
        applyStimulus(8'h33, TIMEOUT - 1);
`ifdef TL_CMD_CHECKSUM_EN
        applyStimulus(8'hA1 ^ 8'h22 ^ 8'h33, TIMEOUT - 1);
`endif

`ifdef TL_CMD_CHECKSUM_EN
        $display("[TB] checksum match and mismatch");
        applyStimulus(8'hA3, 0);
        applyStimulus(8'h0B, 0);
        applyStimulus(8'hB8, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'hA3, 0);
        applyStimulus(8'h0B, 0);
        applyStimulus(8'hB8, 0);
        applyStimulus(8'h11, 0);
`endif

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        #2 rstN = 1'b0;
        #1;
        checkAllZero("async reset");
        checkOutput("queues drained before reset", cmdQ.size() + errQ.size(), 32'd0);
        frameBuf.delete();
        cmdQ.delete();
        errQ.delete();
        modelErrCnt = 0;
        holdType    = 3'd0;
        holdData    = 16'd0;
        @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready after async release", {31'd0, byteReady}, 32'd1);
        sendFrame(8'hA5, 8'h01, 8'hF4);

        $display("[TB] randomized frames");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(8'($urandom), $urandom_range(0, 2));
            end else begin
                b0 = {SYNC, 3'($urandom_range(0, 7))};
                b1 = 8'($urandom);
                b2 = 8'($urandom);
                g0 = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 3);
                g1 = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 3);
                g2 = $urandom_range(0, 3);
                applyStimulus(b0, $urandom_range(0, 2));
                applyStimulus(b1, g0);
                applyStimulus(b2, g1);
`ifdef TL_CMD_CHECKSUM_EN
                ck = b0 ^ b1 ^ b2;
                if ($urandom_range(0, 7) == 0) ck = ck ^ 8'h04;
                applyStimulus(ck, g2);
`else
                ck = 8'h00;
                if (g2 > 0) idleCycles(g2);
`endif
            end
        end
        idleCycles(TIMEOUT + 3);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(8'h00, 0);
        end
        idleCycles(TIMEOUT + 3);
        checkOutput("err_cnt saturated", {24'd0, errCnt}, 32'd255);
        checkOutput("cmd queue empty", cmdQ.size(), 32'd0);
        checkOutput("err queue empty", errQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
